// File: rtl/ram_ss_dxw_rwrw_be_pkg.sv
// Shared types and helpers for the single-clock true dual-port RAM.
// Lane math and read-during-write merge live here.
package ram_pkg;

    localparam int MAX_W = 1024;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;

    function automatic int lanes(input int width, input int lane_width);
        return width / lane_width;
    endfunction

    function automatic logic [MAX_W-1:0] merge_lanes(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_W-1:0] be,
        input int               lane_width
    );
        logic [MAX_W-1:0] r;
        logic [9:0]       li;
        r = old_w;
        for (int i = 0; i < MAX_W; i++) begin
            li = 10'(i / lane_width);
            r[i] = be[li] ? new_w[i] : old_w[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_ss_dxw_rwrw_be_if.sv
// One RAM access port: request, write lanes and registered read data.
// Instantiated once per port.
interface ram_ss_dxw_rwrw_be_if #(
    parameter int DEPTH      = 512,
    parameter int WIDTH      = 32,
    parameter int LANE_WIDTH = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int L  = WIDTH / LANE_WIDTH;

    logic             en;
    logic             wren;
    logic [L-1:0]     byteena;
    logic [AW-1:0]    address;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q;
    logic             q_valid;

    modport master (
        output en, wren, byteena, address, data,
        input  q, q_valid
    );

    modport slave (
        input  en, wren, byteena, address, data,
        output q, q_valid
    );

endinterface

// File: rtl/ram_ss_dxw_rwrw_be_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero.
// busy stays high from reset until the last word is written.
module ram_clear_seq #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    import ram_pkg::*;

    clr_state_e    state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        unique case (state)
            ST_CLEAR: begin
                ptr_nx = ptr + 1'b1;
                if (ptr == AW'(DEPTH - 1)) begin
                    state_nx = ST_IDLE;
                    ptr_nx   = '0;
                end
            end
            ST_IDLE: ;
        endcase
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/ram_ss_dxw_rwrw_be.sv
// Single-clock true dual-port RAM with byte lanes, selectable RDW mode,
// optional output register and optional post-reset clear.
module ram_ss_dxw_rwrw_be #(
    parameter int DEPTH          = 512,
    parameter int WIDTH          = 32,
    parameter int LANE_WIDTH     = 8,
    parameter int RDW_NEW        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  init_busy,
    ram_ss_dxw_rwrw_be_if.slave   port_a,
    ram_ss_dxw_rwrw_be_if.slave   port_b
);
    import ram_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int L  = lanes(WIDTH, LANE_WIDTH);
    localparam rdw_mode_e MODE =
        (RDW_NEW != 0) ? ram_pkg::RDW_NEW : ram_pkg::RDW_OLD;

    logic [WIDTH-1:0] ram [DEPTH];

    logic             busy;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;

    generate
        if (CLEAR_ON_RESET != 0) begin : g_clr
            ram_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr (
                .clock    (clock),
                .reset_n  (reset_n),
                .busy     (busy),
                .clr_we   (clr_we),
                .clr_addr (clr_addr)
            );
        end else begin : g_noclr
            assign busy     = 1'b0;
            assign clr_we   = 1'b0;
            assign clr_addr = '0;
        end
    endgenerate

    assign init_busy = busy;

    logic             acc_a, acc_b;
    logic             in_a, in_b;
    logic [AW-1:0]    wa_addr;
    logic [L-1:0]     wa_be, wb_be;
    logic [WIDTH-1:0] wa_data;

    assign acc_a = port_a.en & ~busy;
    assign acc_b = port_b.en & ~busy;
    assign in_a  = {1'b0, port_a.address} < (AW+1)'(DEPTH);
    assign in_b  = {1'b0, port_b.address} < (AW+1)'(DEPTH);

    // The clear sequencer borrows port A's write path while busy.
    assign wa_addr = busy ? clr_addr : port_a.address;
    assign wa_data = busy ? '0 : port_a.data;
    assign wa_be   = busy ? {L{clr_we}}
                          : ({L{acc_a & port_a.wren & in_a}} & port_a.byteena);
    assign wb_be   = {L{acc_b & port_b.wren & in_b}} & port_b.byteena;

    // B first so that A's later assignment wins on shared lanes.
    always_ff @(posedge clock) begin
        for (int i = 0; i < L; i++) begin
            if (wb_be[i])
                ram[port_b.address][i*LANE_WIDTH +: LANE_WIDTH]
                    <= port_b.data[i*LANE_WIDTH +: LANE_WIDTH];
            if (wa_be[i])
                ram[wa_addr][i*LANE_WIDTH +: LANE_WIDTH]
                    <= wa_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    logic [WIDTH-1:0] d1_a, d1_b;
    logic             v1_a, v1_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d1_a <= '0;
            v1_a <= 1'b0;
        end else begin
            v1_a <= acc_a;
            if (acc_a) begin
                if (!in_a)
                    d1_a <= '0;
                else if (MODE == ram_pkg::RDW_NEW && port_a.wren)
                    d1_a <= WIDTH'(merge_lanes(MAX_W'(ram[port_a.address]),
                                               MAX_W'(port_a.data),
                                               MAX_W'(port_a.byteena),
                                               LANE_WIDTH));
                else
                    d1_a <= ram[port_a.address];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d1_b <= '0;
            v1_b <= 1'b0;
        end else begin
            v1_b <= acc_b;
            if (acc_b) begin
                if (!in_b)
                    d1_b <= '0;
                else if (MODE == ram_pkg::RDW_NEW && port_b.wren)
                    d1_b <= WIDTH'(merge_lanes(MAX_W'(ram[port_b.address]),
                                               MAX_W'(port_b.data),
                                               MAX_W'(port_b.byteena),
                                               LANE_WIDTH));
                else
                    d1_b <= ram[port_b.address];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] q2_a, q2_b;
            logic             v2_a, v2_b;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q2_a <= '0;
                    q2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) q2_a <= d1_a;
                    if (v1_b) q2_b <= d1_b;
                end
            end
            assign port_a.q       = q2_a;
            assign port_a.q_valid = v2_a;
            assign port_b.q       = q2_b;
            assign port_b.q_valid = v2_b;
        end else begin : g_noreg
            assign port_a.q       = d1_a;
            assign port_a.q_valid = v1_a;
            assign port_b.q       = d1_b;
            assign port_b.q_valid = v1_b;
        end
    endgenerate

endmodule
